aemb_xscon: RTL and testbench

Parametrised successor to the AEMB system control unit. Generates the pipeline enable (gena) from the bus handshakes and arbitrates NUM_IRQ external interrupt lines into a single exception request to the core. Supports synchronisation, per-channel edge or level mode, masking, fixed priority and a request/acknowledge handshake. Interrupts are never taken inside an atomic window: a branch delay slot or an IMM prefix pair. Sits beside the AEMB datapath and control, in place of the single-line control unit.

---
 rtl/aemb_xscon.sv | 147 ++++++++++++++
 tb/tb_aemb_xscon.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_xscon.sv
// AEMB system control: pipeline enable and prioritised interrupt arbitration.
// Optional non-maskable interrupt input: define AEMB_XSCON_NMI_EN.

module aemb_xscon_chan #(
  parameter int SYNC = 2
) (
  input  logic gclk,
  input  logic grst,
  input  logic irq,
  input  logic ackHit,
  output logic s,
  output logic ePend
);
  logic [SYNC-1:0] syncQ;
  logic            d;

  always_ff @(posedge gclk)
    if (grst) begin
      syncQ <= '0;
      d     <= 1'b0;
      ePend <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC-2:0], irq};
      d     <= syncQ[SYNC-1];
      // a fresh edge beats a simultaneous acknowledge so it is never lost
      if (syncQ[SYNC-1] & !d) ePend <= 1'b1;
      else if (ackHit)        ePend <= 1'b0;
    end

  assign s = syncQ[SYNC-1];
endmodule

module aemb_xscon #(
  parameter int                 NUM_IRQ   = 8,
  parameter int                 IDW       = 3,
  parameter int                 SYNC      = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = 'h00
) (
  input  logic               gclk,
  input  logic               grst,
  input  logic [5:0]         rOPC,
  input  logic               rMSR_IE,
  input  logic               rDWBSTB,
  input  logic               dwb_ack_i,
  input  logic               iwb_ack_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_msk_i,
  input  logic               xce_ack_i,
`ifdef AEMB_XSCON_NMI_EN
  input  logic               nmi_i,
`endif
  output logic               gena,
  output logic               xce_req_o,
  output logic [IDW-1:0]     xce_id_o,
  output logic [NUM_IRQ-1:0] irq_pend_o
);
  typedef enum logic [1:0] {IDLE, PEND, REQ} state_t;

  state_t             state, nxt;
  logic               fNCLR, rNCLR, atomOk, ackReq, anyReq;
  logic [NUM_IRQ-1:0] sVec, ePend, pend, elig, ackHit;
  logic [IDW-1:0]     winId, rId;

  assign gena = !((rDWBSTB ^ dwb_ack_i) | !iwb_ack_i);

  // branch delay slots and IMM prefixes must not be split by an exception
  assign fNCLR  = rOPC inside {6'o46, 6'o56, 6'o47, 6'o57, 6'o55, 6'o54};
  assign atomOk = !fNCLR & !rNCLR;

  always_ff @(posedge gclk)
    if (grst)      rNCLR <= 1'b0;
    else if (gena) rNCLR <= fNCLR;

  assign ackReq = xce_ack_i & (state == REQ);

  for (genvar n = 0; n < NUM_IRQ; n++) begin : gAck
    assign ackHit[n] = ackReq & (rId == IDW'(n));
  end

  aemb_xscon_chan #(.SYNC(SYNC)) uChan [NUM_IRQ-1:0] (
    .gclk   (gclk),
    .grst   (grst),
    .irq    (irq_i),
    .ackHit (ackHit),
    .s      (sVec),
    .ePend  (ePend)
  );

  assign pend = (ePend & EDGE_MASK) | (sVec & ~EDGE_MASK);
  assign elig = pend & irq_msk_i;

`ifdef AEMB_XSCON_NMI_EN
  logic [SYNC-1:0] nmiSync;
  logic            nmiD, nmiPend, nmiAck;

  assign nmiAck = ackReq & (rId == '1);

  always_ff @(posedge gclk)
    if (grst) begin
      nmiSync <= '0;
      nmiD    <= 1'b0;
      nmiPend <= 1'b0;
    end else begin
      nmiSync <= {nmiSync[SYNC-2:0], nmi_i};
      nmiD    <= nmiSync[SYNC-1];
      if (nmiSync[SYNC-1] & !nmiD) nmiPend <= 1'b1;
      else if (nmiAck)             nmiPend <= 1'b0;
    end

  assign anyReq = ((|elig) & rMSR_IE) | nmiPend;
`else
  assign anyReq = (|elig) & rMSR_IE;
`endif

  always_comb begin
    winId = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (elig[i]) winId = IDW'(i);
`ifdef AEMB_XSCON_NMI_EN
    if (nmiPend) winId = '1;
`endif
  end

  always_ff @(posedge gclk)
    if (grst) state <= IDLE;
    else      state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (anyReq) nxt = PEND;
      PEND:    if (!anyReq) nxt = IDLE;
               else if (gena & atomOk) nxt = REQ;
      REQ:     if (xce_ack_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // the ID is frozen for the whole request so the acknowledge clears the right channel
  always_ff @(posedge gclk)
    if (grst)                            rId <= '0;
    else if (state == PEND && nxt == REQ) rId <= winId;

  assign xce_req_o  = (state == REQ);
  assign xce_id_o   = rId;
  assign irq_pend_o = pend;
endmodule

// File: tb/tb_aemb_xscon.sv
// Randomised self-checking bench for aemb_xscon (channel 1 edge, others level).
module tb_aemb_xscon;
  localparam int NUM_IRQ = 8;
  localparam int IDW     = 3;
  localparam int SYNC    = 2;
  localparam logic [NUM_IRQ-1:0] EDGE_MASK = 8'h02;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  logic [5:0] rOPC = '0;
  logic rMSR_IE = 1'b0, rDWBSTB = 1'b0, dwb_ack_i = 1'b0, iwb_ack_i = 1'b1;
  logic [NUM_IRQ-1:0] irq_i = '0, irq_msk_i = '0;
  logic xce_ack_i = 1'b0;
`ifdef AEMB_XSCON_NMI_EN
  logic nmi = 1'b0;
`endif
  logic gena, xce_req_o;
  logic [IDW-1:0] xce_id_o;
  logic [NUM_IRQ-1:0] irq_pend_o;

  int checks = 0;
  int errors = 0;

  aemb_xscon #(.NUM_IRQ(NUM_IRQ), .IDW(IDW), .SYNC(SYNC), .EDGE_MASK(EDGE_MASK)) dut (
    .gclk(gclk), .grst(grst), .rOPC(rOPC), .rMSR_IE(rMSR_IE), .rDWBSTB(rDWBSTB),
    .dwb_ack_i(dwb_ack_i), .iwb_ack_i(iwb_ack_i), .irq_i(irq_i), .irq_msk_i(irq_msk_i),
    .xce_ack_i(xce_ack_i),
`ifdef AEMB_XSCON_NMI_EN
    .nmi_i(nmi),
`endif
    .gena(gena), .xce_req_o(xce_req_o), .xce_id_o(xce_id_o), .irq_pend_o(irq_pend_o)
  );

  always #5 gclk = ~gclk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge gclk); #1; end
  endtask

  // edges until xce_req_o rises, -1 when the budget runs out
  task automatic waitReq(output int cyc);
    int k = 0;
    while (!xce_req_o && k < 20) begin tick(1); k++; end
    cyc = xce_req_o ? k : -1;
  endtask

  task automatic ackPulse();
    xce_ack_i = 1'b1; tick(1); xce_ack_i = 1'b0;
  endtask

  function automatic int pickLevel();
    int c;
    do c = $urandom_range(0, NUM_IRQ-1); while (EDGE_MASK[c]);
    return c;
  endfunction

  task automatic test_reset();
    grst = 1'b1; irq_i = '0; tick(3); grst = 1'b0; tick(1);
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", xce_req_o); end
    checks++; if (xce_id_o !== '0) begin errors++; $display("FAIL reset_id got %0d want 0", xce_id_o); end
    checks++; if (irq_pend_o !== '0) begin errors++; $display("FAIL reset_pend got %h want 00", irq_pend_o); end
    checks++; if (gena !== 1'b1) begin errors++; $display("FAIL reset_gena got %b want 1", gena); end
  endtask

  task automatic test_gena();
    logic exp;
    repeat (24) begin
      rDWBSTB = 1'($urandom); dwb_ack_i = 1'($urandom); iwb_ack_i = 1'($urandom);
      #1;
      // pipeline runs only when the instruction is fetched and no data access is outstanding
      exp = iwb_ack_i && (rDWBSTB == dwb_ack_i);
      checks++; if (gena !== exp) begin errors++;
        $display("FAIL gena stb=%b dack=%b iack=%b got %b want %b", rDWBSTB, dwb_ack_i, iwb_ack_i, gena, exp); end
    end
    rDWBSTB = 1'b0; dwb_ack_i = 1'b0; iwb_ack_i = 1'b1; tick(2);
  endtask

  task automatic test_level(input int c);
    int cyc;
    rMSR_IE = 1'b1; irq_msk_i = '1;
    irq_i[c] = 1'b1;
    waitReq(cyc);
    checks++; if (cyc != SYNC + 2) begin errors++; $display("FAIL level_latency ch%0d got %0d want %0d", c, cyc, SYNC + 2); end
    checks++; if (xce_id_o !== IDW'(c)) begin errors++; $display("FAIL level_id got %0d want %0d", xce_id_o, c); end
    irq_i[c] = 1'b0; tick(SYNC + 1);
    checks++; if (xce_req_o !== 1'b1 || xce_id_o !== IDW'(c)) begin errors++;
      $display("FAIL level_hold req=%b id=%0d want 1 id %0d", xce_req_o, xce_id_o, c); end
    ackPulse();
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL level_ack got %b want 0", xce_req_o); end
    tick(3);
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL level_quiet got %b want 0", xce_req_o); end
  endtask

  task automatic test_priority(input int a, input int b);
    int cyc, lo, hi;
    lo = (a < b) ? a : b; hi = (a < b) ? b : a;
    irq_i[a] = 1'b1; irq_i[b] = 1'b1;
    waitReq(cyc);
    checks++; if (cyc < 0 || xce_id_o !== IDW'(lo)) begin errors++;
      $display("FAIL prio_first cyc=%0d got %0d want %0d", cyc, xce_id_o, lo); end
    irq_i[lo] = 1'b0; tick(SYNC + 1);
    ackPulse();
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL prio_ack got %b want 0", xce_req_o); end
    waitReq(cyc);
    checks++; if (cyc != 2 || xce_id_o !== IDW'(hi)) begin errors++;
      $display("FAIL prio_second cyc=%0d id=%0d want cyc 2 id %0d", cyc, xce_id_o, hi); end
    irq_i[hi] = 1'b0; tick(SYNC + 1); ackPulse(); tick(3);
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL prio_done got %b want 0", xce_req_o); end
  endtask

  task automatic test_atomic();
    logic [5:0] atom [6];
    int c;
    atom = '{6'o46, 6'o56, 6'o47, 6'o57, 6'o55, 6'o54};
    repeat (3) begin
      c = pickLevel();
      rOPC = atom[$urandom_range(0, 5)];
      irq_i[c] = 1'b1; tick(SYNC + 1 + $urandom_range(0, 3));
      checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL atomic_block opc=%o got %b want 0", rOPC, xce_req_o); end
      rOPC = 6'($urandom_range(0, 31));
      tick(1);
      checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL atomic_rnclr got %b want 0", xce_req_o); end
      tick(1);
      checks++; if (xce_req_o !== 1'b1 || xce_id_o !== IDW'(c)) begin errors++;
        $display("FAIL atomic_release req=%b id=%0d want 1 id %0d", xce_req_o, xce_id_o, c); end
      irq_i[c] = 1'b0; rOPC = '0; tick(SYNC + 1); ackPulse(); tick(3);
    end
  endtask

  task automatic test_edge();
    int cyc;
    rMSR_IE = 1'b0; irq_msk_i = '1;
    irq_i[1] = 1'b1; tick(1); irq_i[1] = 1'b0; tick(SYNC + 1);
    checks++; if (irq_pend_o[1] !== 1'b1 || xce_req_o !== 1'b0) begin errors++;
      $display("FAIL edge_latch pend=%b req=%b want pend 1 req 0", irq_pend_o[1], xce_req_o); end
    irq_msk_i = 8'hFD; rMSR_IE = 1'b1; tick(4);
    checks++; if (irq_pend_o[1] !== 1'b1 || xce_req_o !== 1'b0) begin errors++;
      $display("FAIL edge_masked pend=%b req=%b want pend 1 req 0", irq_pend_o[1], xce_req_o); end
    irq_msk_i = '1;
    waitReq(cyc);
    checks++; if (cyc != 2 || xce_id_o !== IDW'(1)) begin errors++;
      $display("FAIL edge_req cyc=%0d id=%0d want cyc 2 id 1", cyc, xce_id_o); end
    ackPulse();
    checks++; if (irq_pend_o[1] !== 1'b0 || xce_req_o !== 1'b0) begin errors++;
      $display("FAIL edge_clear pend=%b req=%b want 0 0", irq_pend_o[1], xce_req_o); end
    tick(3);
  endtask

  task automatic test_gena_stall();
    int c = pickLevel();
    rDWBSTB = 1'b1; dwb_ack_i = 1'b0;
    irq_i[c] = 1'b1; tick(SYNC + 4);
    checks++; if (gena !== 1'b0 || xce_req_o !== 1'b0) begin errors++;
      $display("FAIL stall_hold gena=%b req=%b want 0 0", gena, xce_req_o); end
    dwb_ack_i = 1'b1; #1;
    checks++; if (gena !== 1'b1) begin errors++; $display("FAIL stall_gena got %b want 1", gena); end
    tick(1);
    checks++; if (xce_req_o !== 1'b1 || xce_id_o !== IDW'(c)) begin errors++;
      $display("FAIL stall_req req=%b id=%0d want 1 id %0d", xce_req_o, xce_id_o, c); end
    dwb_ack_i = 1'b0; irq_i[c] = 1'b0; tick(SYNC + 1);
    ackPulse();
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL stall_ack got %b want 0", xce_req_o); end
    rDWBSTB = 1'b0; tick(3);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int c = pickLevel();
    irq_i[c] = 1'b1; waitReq(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL rstmid_req got %b want 1", xce_req_o); end
    grst = 1'b1; tick(1);
    checks++; if (xce_req_o !== 1'b0 || xce_id_o !== '0) begin errors++;
      $display("FAIL rstmid_drop req=%b id=%0d want 0 0", xce_req_o, xce_id_o); end
    irq_i = '0; tick(2); grst = 1'b0; tick(SYNC + 2);
    checks++; if (xce_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b want 0", xce_req_o); end
  endtask

  task automatic test_random_pend();
    logic [NUM_IRQ-1:0] hist [SYNC+2];
    logic [NUM_IRQ-1:0] exp;
    logic sticky = 1'b0;
    int cyc;
    rMSR_IE = 1'b0; irq_i = '0; tick(SYNC + 2);
    for (int k = 0; k < SYNC + 2; k++) hist[k] = '0;
    for (int it = 0; it < 40; it++) begin
      irq_i = NUM_IRQ'($urandom);
      if (it == 4) irq_i[1] = 1'b0;
      if (it == 5) irq_i[1] = 1'b1;
      irq_msk_i = NUM_IRQ'($urandom);
      tick(1);
      for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_i;
      // a line seen high after being seen low latches until acknowledged
      if (hist[SYNC][1] && !hist[SYNC+1][1]) sticky = 1'b1;
      exp = (hist[SYNC-1] & ~EDGE_MASK) | (sticky ? EDGE_MASK : '0);
      checks++; if (irq_pend_o !== exp || xce_req_o !== 1'b0) begin errors++;
        $display("FAIL rand_pend it=%0d got %h req %b want %h req 0", it, irq_pend_o, xce_req_o, exp); end
    end
    irq_i = '0; irq_msk_i = '0; tick(SYNC + 2);
    checks++; if (irq_pend_o !== 8'h02) begin errors++; $display("FAIL rand_settle got %h want 02", irq_pend_o); end
    irq_msk_i = '1; rMSR_IE = 1'b1; waitReq(cyc);
    checks++; if (cyc < 0 || xce_id_o !== IDW'(1)) begin errors++;
      $display("FAIL rand_req cyc=%0d id=%0d want id 1", cyc, xce_id_o); end
    ackPulse();
    checks++; if (irq_pend_o !== '0) begin errors++; $display("FAIL rand_clear got %h want 00", irq_pend_o); end
  endtask

  initial begin
    int a, b;
    test_reset();
    test_gena();
    test_level(3);
    repeat (2) test_level(pickLevel());
    test_priority(5, 2);
    repeat (2) begin
      a = pickLevel();
      do b = pickLevel(); while (b == a);
      test_priority(a, b);
    end
    test_atomic();
    test_edge();
    test_gena_stall();
    test_reset_mid();
    test_random_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
